// File: rtl/pattern_detector_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The KMP border table and the per-bit transition tables are computed
// here at elaboration so the detector only needs a small table lookup.
package pattern_detector_pkg;

    localparam int MAX_LEN = 16;
    localparam int DEF_LEN = 4;
    localparam logic [DEF_LEN-1:0] DEF_PATTERN = 4'b1011;
    localparam int DEF_CNT_W = 8;

    // Entry i is the longest proper border of the first i pattern bits.
    typedef logic [MAX_LEN:0][3:0] borderTable_t;
    // Entry k is the next matched-prefix length from state k for one input value.
    typedef logic [MAX_LEN-1:0][3:0] nextTable_t;

    // Width of the matched-prefix register; it holds 0..len-1.
    function automatic int stateWidth(int len);
        return (len <= 2) ? 1 : $clog2(len);
    endfunction

    // Pattern bit idx in arrival order; the first bit received is the MSB.
    function automatic logic patBit(logic [MAX_LEN-1:0] pat, int len, int idx);
        logic [MAX_LEN-1:0] shifted;
        shifted = pat >> (len - 1 - idx);
        return shifted[0];
    endfunction

    // Classic KMP failure function over prefix lengths 0..len.
    function automatic borderTable_t buildBorders(logic [MAX_LEN-1:0] pat, int len);
        borderTable_t fail;
        int k;
        fail = '0;
        for (int i = 2; i <= len; i++) begin
            k = int'(fail[5'(i - 1)]);
            while (k > 0 && patBit(pat, len, k) != patBit(pat, len, i - 1))
                k = int'(fail[5'(k)]);
            if (patBit(pat, len, k) == patBit(pat, len, i - 1))
                k++;
            fail[5'(i)] = 4'(k);
        end
        return fail;
    endfunction

    // Transition table for one input value; a completed match falls back to
    // the full-pattern border when overlapping, otherwise restarts at 0.
    function automatic nextTable_t buildNextTable(logic [MAX_LEN-1:0] pat, int len,
                                                  int overlap, logic x);
        borderTable_t fail;
        nextTable_t tbl;
        int j;
        fail = buildBorders(pat, len);
        tbl = '0;
        for (int k = 0; k < len; k++) begin
            j = k;
            while (j > 0 && patBit(pat, len, j) != x)
                j = int'(fail[5'(j)]);
            if (patBit(pat, len, j) == x)
                j++;
            if (j == len)
                j = (overlap != 0) ? int'(fail[5'(len)]) : 0;
            tbl[4'(k)] = 4'(j);
        end
        return tbl;
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Serial data / match bundle between a bit source and the pattern detector.
// CNT_W must match the CNT_W of the detector attached to it.
interface pattern_detector_if
    import pattern_detector_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             en;
    logic             a;
    logic             b;
    logic             c;
    logic [CNT_W-1:0] count;

    modport master (output en, output a, input b, input c, input count);
    modport slave  (input en, input a, output b, output c, output count);

endinterface

// File: rtl/pattern_detector_cnt.sv
// Saturating match counter: increments on each match pulse and sticks at all-ones.
module pattern_detector_cnt
    import pattern_detector_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Next count: add one on a match unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector built on a KMP automaton: the state is the length
// of the longest pattern prefix that ends the accepted bit stream.
// b is the combinational (Mealy) match, c is b delayed one clock.
// Define PATTERN_DETECTOR_COUNT_EN to include the saturating match counter;
// without it count is tied to zero.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int             LEN     = DEF_LEN,
    parameter logic [LEN-1:0] PATTERN = LEN'(DEF_PATTERN),
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = DEF_CNT_W
) (
    input logic               clock,
    input logic               reset,
    pattern_detector_if.slave bus
);

    localparam int SW = stateWidth(LEN);
    localparam logic [SW-1:0] LAST_K = SW'(LEN - 1);
    localparam nextTable_t NEXT_ON0 = buildNextTable(16'(PATTERN), LEN, OVERLAP, 1'b0);
    localparam nextTable_t NEXT_ON1 = buildNextTable(16'(PATTERN), LEN, OVERLAP, 1'b1);

    logic [SW-1:0] k_q, k_d;
    logic          c_q;
    logic          matchNow;

    // Next matched-prefix length and the Mealy match for an accepted bit;
    // reset or an idle cycle holds the state and suppresses the match.
    always_comb begin
        k_d      = k_q;
        matchNow = 1'b0;
        if (!reset && bus.en) begin
            matchNow = (k_q == LAST_K) && (bus.a == PATTERN[0]);
            k_d      = bus.a ? SW'(NEXT_ON1[4'(k_q)]) : SW'(NEXT_ON0[4'(k_q)]);
        end
    end

    // State and delayed-match registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            k_q <= '0;
            c_q <= 1'b0;
        end else begin
            k_q <= k_d;
            c_q <= matchNow;
        end
    end

    assign bus.b = matchNow;
    assign bus.c = c_q;

`ifdef PATTERN_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] countVal;

    pattern_detector_cnt #(
        .CNT_W (CNT_W)
    ) uCnt (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (matchNow),
        .count_o (countVal)
    );

    assign bus.count = countVal;
`else
    assign bus.count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Testbench for pattern_detector: three instances (overlapping, restarting,
// and a 2-bit counter) share one stimulus stream. A directed vector table
// covers the documented scenarios, then random traffic is compared with a
// window-based reference model.
module tb_pattern_detector;

    localparam int LEN = 4;
    localparam logic [3:0] PAT = 4'b1011;
`ifdef PATTERN_DETECTOR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic r;
        logic e;
        logic a;
        logic expB;
        logic expB0;
        logic expC;
        int   expCnt;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    vec_t vecs[$];

    // Reference model state per instance.
    int       overlapCfg [3];
    int       cntMax     [3];
    int       mSeen      [3];
    logic [2:0] mHist    [3];
    logic     mC         [3];
    int       mCnt       [3];
    logic     expB       [3];

    pattern_detector_if #(.CNT_W(8)) busA ();
    pattern_detector_if #(.CNT_W(8)) busB ();
    pattern_detector_if #(.CNT_W(2)) busC ();

    pattern_detector #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1), .CNT_W(8)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    pattern_detector #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(0), .CNT_W(8)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    pattern_detector #(.LEN(LEN), .PATTERN(PAT), .OVERLAP(1), .CNT_W(2)) dutC (
        .clock (clock),
        .reset (reset),
        .bus   (busC)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic x);
        @(posedge clock);
        #1;
        reset   = r;
        busA.en = e; busA.a = x;
        busB.en = e; busB.a = x;
        busC.en = e; busC.a = x;
    endtask

    task automatic addVec(input logic r, input logic e, input logic x, input logic b,
                          input logic b0, input logic c, input int cnt);
        vec_t v;
        v.r = r; v.e = e; v.a = x; v.expB = b; v.expB0 = b0; v.expC = c; v.expCnt = cnt;
        vecs.push_back(v);
    endtask

    // One clock of stimulus: drive, predict from the model, check mid-cycle,
    // then advance the model across the coming rising edge.
    task automatic runStep(input logic r, input logic e, input logic x, input string tag);
        logic actB [3];
        logic actC [3];
        int   actN [3];
        applyStimulus(r, e, x);
        for (int d = 0; d < 3; d++)
            expB[d] = !r && e && (mSeen[d] >= LEN - 1) && ({mHist[d], x} == PAT);
        @(negedge clock);
        actB[0] = busA.b; actC[0] = busA.c; actN[0] = int'(busA.count);
        actB[1] = busB.b; actC[1] = busB.c; actN[1] = int'(busB.count);
        actB[2] = busC.b; actC[2] = busC.c; actN[2] = int'(busC.count);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s dut%0d b", tag, d), int'(actB[d]), int'(expB[d]));
            checkOutput($sformatf("%s dut%0d c", tag, d), int'(actC[d]), int'(mC[d]));
            checkOutput($sformatf("%s dut%0d count", tag, d), actN[d], CNT_ON ? mCnt[d] : 0);
        end
        for (int d = 0; d < 3; d++) begin
            mC[d] = expB[d];
            if (r) begin
                mSeen[d] = 0;
                mHist[d] = '0;
                mCnt[d]  = 0;
            end else if (e) begin
                if (expB[d] && overlapCfg[d] == 0) begin
                    mSeen[d] = 0;
                end else begin
                    mHist[d] = {mHist[d][1:0], x};
                    if (mSeen[d] < 16) mSeen[d]++;
                end
                if (expB[d] && mCnt[d] < cntMax[d]) mCnt[d]++;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        busA.en = 1'b0; busA.a = 1'b0;
        busB.en = 1'b0; busB.a = 1'b0;
        busC.en = 1'b0; busC.a = 1'b0;
        overlapCfg[0] = 1; overlapCfg[1] = 0; overlapCfg[2] = 1;
        cntMax[0] = 255;   cntMax[1] = 255;   cntMax[2] = 3;
        for (int d = 0; d < 3; d++) begin
            mSeen[d] = 0; mHist[d] = '0; mC[d] = 1'b0; mCnt[d] = 0; expB[d] = 1'b0;
        end

        // reset two cycles (second with en=1 and a would-be bit), then 1,0,1,1
        addVec(1,0,0, 0,0,0,0); addVec(1,1,1, 0,0,0,0);
        addVec(0,1,1, 0,0,0,0); addVec(0,1,0, 0,0,0,0);
        addVec(0,1,1, 0,0,0,0); addVec(0,1,1, 1,1,0,0);
        addVec(0,0,0, 0,0,1,1); addVec(0,0,0, 0,0,0,1);
        // overlap: 1,0,1,1,0,1,1
        addVec(1,0,0, 0,0,0,1); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,0, 0,0,0,0); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,1, 1,1,0,0); addVec(0,1,0, 0,0,1,1);
        addVec(0,1,1, 0,0,0,1); addVec(0,1,1, 1,0,0,1);
        addVec(0,0,0, 0,0,1,2);
        // idle gap inside the pattern
        addVec(1,0,0, 0,0,0,2); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,0, 0,0,0,0); addVec(0,0,1, 0,0,0,0);
        addVec(0,1,1, 0,0,0,0); addVec(0,1,1, 1,1,0,0);
        addVec(0,0,0, 0,0,1,1);
        // reset mid-pattern, coinciding with the completing bit
        addVec(1,0,0, 0,0,0,1); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,0, 0,0,0,0); addVec(0,1,1, 0,0,0,0);
        addVec(1,1,1, 0,0,0,0); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,0, 0,0,0,0); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,1, 1,1,0,0); addVec(0,0,0, 0,0,1,1);
        // KMP fallback on 1,1,0,1,1 then ten zeros
        addVec(1,0,0, 0,0,0,1); addVec(0,1,1, 0,0,0,0);
        addVec(0,1,1, 0,0,0,0); addVec(0,1,0, 0,0,0,0);
        addVec(0,1,1, 0,0,0,0); addVec(0,1,1, 1,1,0,0);
        addVec(0,1,0, 0,0,1,1);
        for (int i = 0; i < 9; i++) addVec(0,1,0, 0,0,0,1);

        $display("[TB] directed vectors: %0d", vecs.size());
        foreach (vecs[i]) begin
            runStep(vecs[i].r, vecs[i].e, vecs[i].a, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d tbl b", i), int'(busA.b), int'(vecs[i].expB));
            checkOutput($sformatf("vec%0d tbl b nooverlap", i), int'(busB.b), int'(vecs[i].expB0));
            checkOutput($sformatf("vec%0d tbl c", i), int'(busA.c), int'(vecs[i].expC));
            checkOutput($sformatf("vec%0d tbl count", i), int'(busA.count),
                        CNT_ON ? vecs[i].expCnt : 0);
        end

        // five back-to-back overlapping matches: 1011 then 011 four times
        runStep(1'b1, 1'b0, 1'b0, "sat rst");
        runStep(1'b0, 1'b1, 1'b1, "sat");
        runStep(1'b0, 1'b1, 1'b0, "sat");
        runStep(1'b0, 1'b1, 1'b1, "sat");
        runStep(1'b0, 1'b1, 1'b1, "sat");
        for (int i = 0; i < 4; i++) begin
            runStep(1'b0, 1'b1, 1'b0, "sat");
            runStep(1'b0, 1'b1, 1'b1, "sat");
            runStep(1'b0, 1'b1, 1'b1, "sat");
        end
        runStep(1'b0, 1'b0, 1'b0, "sat idle");
        checkOutput("sat count cnt2", int'(busC.count), CNT_ON ? 3 : 0);
        checkOutput("sat count cnt8", int'(busA.count), CNT_ON ? 5 : 0);
        checkOutput("sat count nooverlap", int'(busB.count), CNT_ON ? 3 : 0);
        runStep(1'b0, 1'b1, 1'b1, "sat hold");
        checkOutput("sat hold cnt2", int'(busC.count), CNT_ON ? 3 : 0);

        // random traffic with occasional resets and idle cycles
        runStep(1'b1, 1'b0, 1'b0, "rnd rst");
        for (int i = 0; i < 400; i++) begin
            runStep(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 Parameter LEN, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: LEN-bit target; PATTERN[LEN-1] is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 means overlapping matches are detected; 0 restarts detection after each match.
REQ-004 Parameter CNT_W, default 8: match counter width.
REQ-005 clock  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  reset, synchronous and active-high.
REQ-007 en  input  1  sample qualifier; a is consumed only when en=1.
REQ-008 a  input  1  serial data bit.
REQ-009 b  output  1  Mealy match, combinational, asserted in the cycle the final pattern bit is presented.
REQ-010 c  output  1  Moore match, registered, asserted exactly one cycle after b.
REQ-011 count  output  CNT_W  saturating number of matches since reset.

Function
REQ-012 The state register shall hold k (0..LEN-1), the length of the longest PATTERN prefix equal to a suffix of the accepted bits, with k<LEN.
REQ-013 On an accepted bit, the block shall set b = (k==LEN-1) && (a == PATTERN[0]); otherwise b = 0.
REQ-014 On an accepted non-matching bit, next k shall be the longest prefix that is a suffix of (the matched prefix followed by a), i.e. KMP fallback, never simply 0.
REQ-015 After a match with OVERLAP=1, next k shall be the length of the longest proper border of PATTERN (1 for 1011).
REQ-016 After a match with OVERLAP=0, next k shall be 0.
REQ-017 With en=0, k and count shall hold, b shall be 0, and c shall load 0 at the next edge.
REQ-018 c shall be loaded with b on every rising edge.
REQ-019 count shall increment by one on each cycle with b=1 and shall hold at 2^CNT_W-1 (no wrap).
REQ-020 Latency: b has 0 cycles from the final bit; c has 1 cycle; count updates 1 cycle after b.

Reset
REQ-021 While reset=1, b shall be forced to 0, and at the edge k shall become 0, c shall become 0 and count shall become 0.
REQ-022 When reset and en=1 occur together, reset shall win and the bit shall be discarded.
REQ-023 Reset in the middle of a pattern shall discard the partial match.

Configuration
REQ-024 With macro PATTERN_DETECTOR_COUNT_EN defined, the saturating counter of REQ-019 shall be present.
REQ-025 Without PATTERN_DETECTOR_COUNT_EN, count shall be tied to 0, no counter flops shall be inferred, and b and c behaviour shall be unchanged.

Structure
REQ-026 Package pattern_detector_pkg shall hold the state-width function (clog2 of LEN), the default LEN/PATTERN/CNT_W constants, and the border-table generation function.
REQ-027 The saturating counter shall be the sub-module pattern_detector_cnt, instantiated only under PATTERN_DETECTOR_COUNT_EN.

Verification
REQ-028 Defaults; reset 2 cycles, then en=1 with a=1,0,1,1 -> b=1 on 4th bit; c=1 the following cycle; count=1.
REQ-029 a=1,0,1,1,0,1,1 -> OVERLAP=1: b at bits 4 and 7, count=2; OVERLAP=0: b at bit 4 only, count=1.
REQ-030 a=1,0,[en=0 with a=1],1,1 -> the gap is ignored; b=1 on the last bit only; b=0 during the gap.
REQ-031 a=1,0,1, then reset 1 cycle, then 1 -> no match; then 0,1,1 -> b=1.
REQ-032 CNT_W=2, 5 consecutive matches -> count reaches 3 and holds; build without macro -> count=0 throughout, b and c identical.
REQ-033 a=1,1,0,1,1 (fallback from k=1 on a repeated 1) -> b=1 on 5th bit; 10 cycles of a=0 -> b=c=0.
